// File: rtl/alu_accu_fetch.sv
// 4-bit datapath slice: program-byte fetch register, combinational ALU and
// accumulator. Operand A is the accumulator and operand B is the data bus.
`timescale 1ns/1ps
module alu_accu_fetch (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       fetch_en_i,
  input  logic [7:0] program_byte_i,
  input  logic       load_acc_i,
  input  logic [2:0] fun_i,
  input  logic [3:0] data_bus_i,
  output logic [3:0] instr_o,
  output logic [3:0] oprnd_o,
  output logic [3:0] accu_o,
  output logic [3:0] alu_out_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [3:0] instr_q, instr_d;
  logic [3:0] oprnd_q, oprnd_d;
  logic [3:0] accu_q,  accu_d;
  logic [4:0] res;

  // Bit 4 of the 5-bit result carries the add carry or the subtract borrow.
  always_comb begin
    res = 5'd0;
    case (fun_i)
      3'b000:  res = {1'b0, accu_q};
      3'b001:  res = {1'b0, accu_q} - {1'b0, data_bus_i};
      3'b010:  res = {1'b0, data_bus_i};
      3'b011:  res = {1'b0, accu_q} + {1'b0, data_bus_i};
      3'b100:  res = {1'b0, ~(accu_q & data_bus_i)};
      default: res = 5'd0;
    endcase
  end

  assign alu_out_o = res[3:0];
  assign carry_o   = res[4];
  assign zero_o    = (res[3:0] == 4'd0);

  always_comb begin
    instr_d = instr_q;
    oprnd_d = oprnd_q;
    accu_d  = accu_q;
    if (fetch_en_i) begin
      instr_d = program_byte_i[7:4];
      oprnd_d = program_byte_i[3:0];
    end
    if (load_acc_i) accu_d = res[3:0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      instr_q <= 4'd0;
      oprnd_q <= 4'd0;
      accu_q  <= 4'd0;
    end else begin
      instr_q <= instr_d;
      oprnd_q <= oprnd_d;
      accu_q  <= accu_d;
    end
  end

  assign instr_o = instr_q;
  assign oprnd_o = oprnd_q;
  assign accu_o  = accu_q;

endmodule

// File: tb/tb_alu_accu_fetch.sv
// Directed bench for alu_accu_fetch: expected output vectors are queued when
// stimulus is applied and compared when the DUT outputs are sampled.
`timescale 1ns/1ps
module tb_alu_accu_fetch;

  logic       clock_i = 1'b0;
  logic       reset_i, fetch_en_i, load_acc_i;
  logic [7:0] program_byte_i;
  logic [2:0] fun_i;
  logic [3:0] data_bus_i;
  logic [3:0] instr_o, oprnd_o, accu_o, alu_out_o;
  logic       carry_o, zero_o;

  alu_accu_fetch dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetch_en_i(fetch_en_i),
    .program_byte_i(program_byte_i), .load_acc_i(load_acc_i), .fun_i(fun_i),
    .data_bus_i(data_bus_i), .instr_o(instr_o), .oprnd_o(oprnd_o),
    .accu_o(accu_o), .alu_out_o(alu_out_o), .carry_o(carry_o), .zero_o(zero_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  logic [3:0] e_instr = 4'd0, e_oprnd = 4'd0, e_accu = 4'd0;
  logic [17:0] exp_q[$];
  string       tag_q[$];

  // Vector layout: {instr, oprnd, accu, alu_out, carry, zero}
  task automatic expect_now(input string tag, input logic [3:0] a, input logic c, input logic z);
    exp_q.push_back({e_instr, e_oprnd, e_accu, a, c, z});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [17:0] exp, obs;
    string tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {instr_o, oprnd_o, accu_o, alu_out_o, carry_o, zero_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed i/o/acc/alu/c/z=%h/%h/%h/%h/%b/%b expected %h/%h/%h/%h/%b/%b",
             tag, obs[17:14], obs[13:10], obs[9:6], obs[5:2], obs[1], obs[0],
             exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic rst, input logic fe, input logic [7:0] pb,
                       input logic la, input logic [2:0] f, input logic [3:0] db);
    reset_i = rst; fetch_en_i = fe; program_byte_i = pb;
    load_acc_i = la; fun_i = f; data_bus_i = db;
  endtask

  task automatic comb_check(input string tag, input logic [3:0] a, input logic c, input logic z);
    #1;
    expect_now(tag, a, c, z);
    check_out();
  endtask

  // Caller updates the register model first; a/c/z are ALU outputs after the edge.
  task automatic edge_check(input string tag, input logic [3:0] a, input logic c, input logic z);
    expect_now(tag, a, c, z);
    @(posedge clock_i);
    #1;
    check_out();
    @(negedge clock_i);
  endtask

  function automatic logic [4:0] ref_alu(input logic [2:0] f, input int a, input int b);
    int r;
    case (f)
      3'b001:  r = (a - b) & 31;
      3'b011:  r = a + b;
      default: r = 0;
    endcase
    return r[4:0];
  endfunction

  initial begin
    @(negedge clock_i);
    drive(1, 1, 8'hA5, 1, 3'b000, 4'h0);
    edge_check("reset_edge1", 4'h0, 0, 1);
    edge_check("reset_edge2", 4'h0, 0, 1);

    drive(0, 1, 8'h3C, 0, 3'b000, 4'h0);
    e_instr = 4'h3; e_oprnd = 4'hC;
    edge_check("fetch_3C", 4'h0, 0, 1);
    drive(0, 0, 8'hFF, 0, 3'b000, 4'h0);
    edge_check("fetch_hold", 4'h0, 0, 1);

    drive(0, 0, 8'hFF, 1, 3'b010, 4'h7);
    comb_check("passB_7_pre", 4'h7, 0, 0);
    e_accu = 4'h7;
    edge_check("load_7", 4'h7, 0, 0);
    drive(0, 0, 8'hFF, 1, 3'b011, 4'h9);
    comb_check("add_7_9_pre", 4'h0, 1, 1);
    e_accu = 4'h0;
    edge_check("add_load_0", 4'h9, 0, 0);

    drive(0, 0, 8'hFF, 1, 3'b010, 4'h5);
    e_accu = 4'h5;
    edge_check("load_5", 4'h5, 0, 0);
    drive(0, 0, 8'hFF, 0, 3'b001, 4'h5);
    comb_check("cmp_5_5", 4'h0, 0, 1);
    data_bus_i = 4'h6;
    comb_check("cmp_5_6", 4'hF, 1, 0);
    edge_check("cmp_hold_acc", 4'hF, 1, 0);

    drive(0, 0, 8'hFF, 1, 3'b010, 4'hC);
    e_accu = 4'hC;
    edge_check("load_C", 4'hC, 0, 0);
    drive(0, 0, 8'hFF, 0, 3'b100, 4'hA);
    comb_check("nand_C_A", 4'h7, 0, 0);
    fun_i = 3'b110; comb_check("rsvd_110", 4'h0, 0, 1);
    fun_i = 3'b101; comb_check("rsvd_101", 4'h0, 0, 1);
    fun_i = 3'b111; comb_check("rsvd_111", 4'h0, 0, 1);
    fun_i = 3'b000; comb_check("passA_C", 4'hC, 0, 0);

    drive(0, 0, 8'hFF, 1, 3'b010, 4'h0);
    e_accu = 4'h0;
    edge_check("load_0", 4'h0, 0, 1);
    drive(0, 0, 8'hFF, 0, 3'b001, 4'h1);
    comb_check("sub_0_1", 4'hF, 1, 0);
    drive(0, 0, 8'hFF, 1, 3'b010, 4'hF);
    e_accu = 4'hF;
    edge_check("load_F", 4'hF, 0, 0);
    drive(0, 0, 8'hFF, 0, 3'b011, 4'h1);
    comb_check("add_F_1", 4'h0, 1, 1);

    drive(0, 1, 8'h5E, 1, 3'b010, 4'h2);
    e_instr = 4'h5; e_oprnd = 4'hE; e_accu = 4'h2;
    edge_check("fetch_and_load", 4'h2, 0, 0);

    drive(0, 1, 8'h3C, 1, 3'b010, 4'h9);
    e_instr = 4'h3; e_oprnd = 4'hC; e_accu = 4'h9;
    edge_check("setup_9_3C", 4'h9, 0, 0);
    drive(1, 1, 8'hA5, 1, 3'b010, 4'h9);
    e_instr = 4'h0; e_oprnd = 4'h0; e_accu = 4'h0;
    edge_check("mid_reset", 4'h9, 0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [2:0] f;
      logic [3:0] b;
      logic [4:0] r;
      f = (i % 2 == 0) ? 3'b011 : 3'b001;
      b = 4'($urandom_range(0, 15));
      r = ref_alu(f, int'(e_accu), int'(b));
      drive(0, 0, 8'h00, 1, f, b);
      comb_check($sformatf("rand_alu_%0d", i), r[3:0], r[4], r[3:0] == 4'd0);
      e_accu = r[3:0];
      r = ref_alu(f, int'(e_accu), int'(b));
      edge_check($sformatf("rand_load_%0d", i), r[3:0], r[4], r[3:0] == 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
